// File: rtl/jelly_round_robin_select.sv
// Rotate-and-priority-encode: finds the first asserted request after i_ptr,
// wrapping modulo NUM. Purely combinational, so other arbiters can reuse it.
module jelly_round_robin_select #(
  parameter int NUM      = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM-1:0]      i_request,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic                o_found,
  output logic [ID_WIDTH-1:0] o_index
);

  int w_idx;

  // Walk from the farthest offset to the nearest so the nearest request wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_idx   = 0;
    for (int k = NUM; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM;
      if (i_request[w_idx]) begin
        o_found = 1'b1;
        o_index = ID_WIDTH'(w_idx);
      end
    end
  end

endmodule

// File: rtl/jelly_data_joint_round_robin.sv
// Packet-aware N:1 stream joint with round-robin fairness; the grant is held
// from the first beat of a packet until its last beat is accepted.
module jelly_data_joint_round_robin #(
  parameter int NUM        = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int USE_LAST   = 1
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      cke,
  input  logic [NUM*DATA_WIDTH-1:0] s_data,
  input  logic [NUM-1:0]            s_last,
  input  logic [NUM-1:0]            s_valid,
  output logic [NUM-1:0]            s_ready,
  output logic [ID_WIDTH-1:0]       m_id,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_gnt;
  logic [ID_WIDTH-1:0]   r_m_id;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic                  r_m_valid;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH-1:0]   w_sel;
  logic                  w_sel_en;
  logic                  w_can_load;
  logic                  w_grant;
  logic                  w_handshake;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

  jelly_round_robin_select #(
    .NUM      (NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_select (
    .i_request (s_valid),
    .i_ptr     (r_ptr),
    .o_found   (w_found),
    .o_index   (w_cand)
  );

  assign w_can_load = !r_m_valid || m_ready;
  assign w_sel      = (r_state == ST_LOCKED) ? r_gnt : w_cand;
  assign w_sel_en   = (r_state == ST_LOCKED) || w_found;
  assign w_grant    = w_sel_en && w_can_load && cke && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_ready
      assign s_ready[gi] = w_grant && (w_sel == ID_WIDTH'(gi));
    end
  endgenerate

  assign w_handshake = |(s_valid & s_ready);
  assign w_sel_data  = s_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  // Without packet framing every beat closes its own packet.
  assign w_sel_last  = (USE_LAST != 0) ? s_last[w_sel] : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= ID_WIDTH'(NUM - 1);
      r_gnt     <= '0;
      r_m_id    <= '0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (cke) begin
      if (w_handshake) begin
        r_m_id    <= w_sel;
        r_m_data  <= w_sel_data;
        r_m_last  <= w_sel_last;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      // Lock and pointer move only on an accepted beat, never during a stall.
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            if (w_sel_last) begin
              r_ptr <= w_sel;
            end else begin
              r_gnt   <= w_sel;
              r_state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_handshake && w_sel_last) begin
            r_ptr   <= r_gnt;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_id    = r_m_id;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_valid = r_m_valid;

endmodule

// File: tb/tb_jelly_data_joint_round_robin.sv
// Directed and randomized checks of the round-robin joint against a
// packet-level reference model of owner / last-served input.
module tb_jelly_data_joint_round_robin;

  localparam int NUM = 4;
  localparam int IW  = 2;
  localparam int DW  = 32;

  logic              reset;
  logic              clk;
  logic              cke;
  logic [NUM*DW-1:0] s_data;
  logic [NUM-1:0]    s_last;
  logic [NUM-1:0]    s_valid;
  logic [NUM-1:0]    s_ready;
  logic [IW-1:0]     m_id;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the output (-1 = nobody) and who was served last.
  int             mo_owner;
  int             mo_lastsvc;
  logic           mo_valid;
  logic [IW-1:0]  mo_id;
  logic [DW-1:0]  mo_data;
  logic           mo_last;
  logic [NUM-1:0] exp_ready;

  jelly_data_joint_round_robin #(
    .NUM        (NUM),
    .ID_WIDTH   (IW),
    .DATA_WIDTH (DW),
    .USE_LAST   (1)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_id    (m_id),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fairness rule: the valid input closest after the last-served one wins.
  function automatic int pick_next(input logic [NUM-1:0] v, input int after);
    int best;
    best = -1;
    for (int i = 0; i < NUM; i++) begin
      if (v[i] && (best < 0 || ((i - after - 1 + NUM) % NUM) < ((best - after - 1 + NUM) % NUM)))
        best = i;
    end
    return best;
  endfunction

  task automatic cycle();
    int w;
    #1;
    exp_ready = '0;
    if (!reset && cke && (!mo_valid || m_ready)) begin
      if (mo_owner >= 0) exp_ready[mo_owner] = 1'b1;
      else begin
        w = pick_next(s_valid, mo_lastsvc);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
    end
    chk("s_ready", 64'(s_ready), 64'(exp_ready));
    @(posedge clk);
    if (reset) begin
      mo_owner = -1; mo_lastsvc = NUM - 1;
      mo_valid = 1'b0; mo_id = '0; mo_data = '0; mo_last = 1'b0;
    end else if (cke) begin
      w = -1;
      for (int i = 0; i < NUM; i++) if (exp_ready[i] && s_valid[i]) w = i;
      if (w >= 0) begin
        mo_valid = 1'b1;
        mo_id    = w[IW-1:0];
        mo_data  = s_data[w*DW +: DW];
        mo_last  = s_last[w];
        if (s_last[w]) begin
          mo_owner = -1; mo_lastsvc = w;
        end else begin
          mo_owner = w;
        end
      end else if (m_ready) begin
        mo_valid = 1'b0;
      end
    end
    #1;
    chk("m_valid", 64'(m_valid), 64'(mo_valid));
    chk("m_id",    64'(m_id),    64'(mo_id));
    chk("m_data",  64'(m_data),  64'(mo_data));
    chk("m_last",  64'(m_last),  64'(mo_last));
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM; i++) s_data[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    logic [IW-1:0] exp_ids [6];
    logic [IW-1:0] seq_id  [4];
    logic          seq_last[4];
    mo_owner = -1; mo_lastsvc = NUM - 1;
    mo_valid = 1'b0; mo_id = '0; mo_data = '0; mo_last = 1'b0;
    reset = 1'b1; cke = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0;

    // Reset
    cycle(); cycle();
    reset = 1'b0;
    chk("reset m_valid", 64'(m_valid), 64'd0);

    // All inputs valid, single-beat packets: strict rotation 0,1,2,3,0,1
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    s_valid = 4'b1111; s_last = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      rand_data();
      cycle();
      chk("rotation id", 64'(m_id), 64'(exp_ids[n]));
      chk("rotation valid", 64'(m_valid), 64'd1);
    end

    // Input 2 sends a 3-beat packet while input 0 waits
    seq_id   = '{2'd2, 2'd2, 2'd2, 2'd0};
    seq_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    s_valid = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      rand_data();
      s_last = {1'b0, (n >= 2), 1'b0, 1'b1};
      if (n == 3) s_valid = 4'b0001;
      cycle();
      chk("packet id", 64'(m_id), 64'(seq_id[n]));
      chk("packet last", 64'(m_last), 64'(seq_last[n]));
    end

    // Lock input 2, reset mid-packet, then 0 must win over 2
    s_valid = 4'b0100; s_last = 4'b0000; rand_data();
    cycle();
    reset = 1'b1; cycle();
    chk("reset drops m_valid", 64'(m_valid), 64'd0);
    reset = 1'b0;
    s_valid = 4'b0101; s_last = 4'b1111; rand_data();
    cycle();
    chk("post-reset grant", 64'(m_id), 64'd0);

    // Randomized traffic with stalls, cke gaps and occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) != 0) s_valid = NUM'($urandom);
      s_last  = NUM'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      cke     = ($urandom_range(0, 7) != 0);
      reset   = ($urandom_range(0, 99) == 0);
      rand_data();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly_data_joint_round_robin.md
Name: jelly_data_joint_round_robin

Overview:
- Packet-aware N:1 joint that shares one output stream between NUM requesters with round-robin fairness.
- Grant is held from the first beat of a packet until its last beat is accepted; beats from different inputs are never interleaved.
- Carries the winning input index as m_id, so downstream logic can route replies.
- Sits where priority-joint behaviour would starve low-priority masters: multi-port memory and DMA request merge, and sharing a single register or FIFO port.

Parameters:
- NUM, 4, number of input streams (>=2).
- ID_WIDTH, 2, width of m_id; must satisfy 2**ID_WIDTH >= NUM.
- DATA_WIDTH, 32, payload width per stream.
- USE_LAST, 1: 1 = lock grant until s_last beat; 0 = every beat is its own packet, so arbitration happens per beat.

Ports:
- reset  input  1  synchronous, active-high
- clk  input  1  single clock, rising edge
- cke  input  1  clock enable; all state frozen when 0
- s_data  input  NUM*DATA_WIDTH  input payloads, stream i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_last  input  NUM  end-of-packet per input (ignored when USE_LAST=0)
- s_valid  input  NUM  input valid
- s_ready  output  NUM  input ready (combinational)
- m_id  output  ID_WIDTH  index of source input (registered)
- m_data  output  DATA_WIDTH  payload (registered)
- m_last  output  1  end-of-packet (registered; forced 1 when USE_LAST=0)
- m_valid  output  1  output valid (registered)
- m_ready  input  1  output ready

Behaviour:
- Reset, on a synchronous clk edge with reset=1, regardless of cke:
  - m_valid=0, m_id=0, m_data=0, m_last=0.
  - state=IDLE; rr pointer=NUM-1, so the first search starts at input 0.
  - s_ready=0 while reset is high.
- Output stage is a one-register pipeline:
  - can_load = !m_valid || m_ready.
  - A handshake on input i occurs when s_valid[i] && s_ready[i] && cke.
  - On a handshake, m_* load {i, s_data[i], s_last[i]} and m_valid=1.
  - Otherwise, if m_ready, m_valid goes to 0.
  - Full throughput: one beat per cycle, latency 1 clk from input handshake to m_valid.
- State machine (2 states):
  - IDLE:
    - cand = first i with s_valid[i]=1, searching (ptr+1)%NUM, (ptr+2)%NUM, ... wrapping.
    - s_ready[cand] = can_load && cke; all other s_ready = 0.
    - On a handshake with last=1 (or USE_LAST=0): stay IDLE, ptr<=cand.
    - On a handshake with last=0: go to LOCKED, gnt<=cand.
    - With no valid input: stay IDLE, ptr unchanged.
  - LOCKED:
    - s_ready[gnt] = can_load && cke; all others 0.
    - If s_valid[gnt] drops mid-packet, stay LOCKED; other inputs stay blocked (no timeout).
    - On a handshake of gnt with last=1: go to IDLE, ptr<=gnt.
- Arbitration is zero-bubble:
  - A new packet may be granted and its first beat accepted in the cycle after the previous last beat.
  - Grant is never evaluated while the output stage is stalled; the cand calculation is combinational, but the lock and ptr update only on a handshake.
- Fairness: after input k finishes, k has the lowest priority. With all inputs continuously valid, service order is 0,1,...,NUM-1,0,...
- cke=0: all s_ready=0; no register changes (including the m_valid drop).
- Indices >= NUM when NUM is not a power of 2 are never produced.
- Reset mid-packet: lock dropped, partial packet abandoned on the output side. Upstream is responsible for flushing; this block does not regenerate m_last.

Decomposition:
- No shared package.
- localparam-level constants (state encoding IDLE=0, LOCKED=1) are local to the module.
- One natural sub-module: jelly_round_robin_select (NUM, ID_WIDTH).
  - Inputs: request vector and ptr.
  - Outputs: found flag and index; purely combinational rotate-and-priority-encode.
  - Reusable by other arbiters in the library.

Test Plan:
- Reset, then all s_valid=4'b1111, every beat last=1, m_ready=1 -> m_id sequence 0,1,2,3,0,1; one beat per clk; first m_valid 1 clk after the first handshake.
- Input 2 sends a 3-beat packet (last on beat 3) while input 0 is valid throughout -> m_id=2,2,2 with m_last=0,0,1, then m_id=0; s_ready[0]=0 during the lock.
- Input 1 locked, s_valid[1] deasserted 2 clks mid-packet, s_valid[3]=1 -> no s_ready[3], m_valid drops after draining; resume beats from 1, then grant 3.
- Hold m_ready=0 for 5 clks with a beat in the output register -> m_valid, m_id and m_data stable; all s_ready=0; no ptr change. Release -> next beat accepted the same cycle m_ready=1.
- Toggle cke=0 for 3 clks mid-stream -> outputs frozen and no handshakes; stream continues identically after cke=1.
- Assert reset during a locked packet from input 2 -> next cycle m_valid=0; after release, with inputs 2 and 0 valid, grant goes to 0 first (ptr=NUM-1).
